i2c_txn_scheduler: RTL and testbench

- Shares one I2C controller between N_REQ local requesters, so several agents can issue I2C transactions without each owning a controller.
- Arbitrates requests round-robin and latches the winner's transaction fields.
- Drives the controller's start/addr/data/byte-count inputs, then tracks controller busy to completion.
- Returns a per-requester done/err pulse and the received data.

---
 rtl/i2c_txn_scheduler_pkg.sv | 41 ++++
 rtl/i2c_txn_scheduler_rr_arbiter.sv | 40 ++++
 rtl/i2c_txn_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_i2c_txn_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_txn_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// i2c_sched_pkg
// Shared types for the I2C transaction scheduler: FSM state encoding, payload
// width helpers and the latched-transaction record driven onto the controller.
// -----------------------------------------------------------------------------
package i2c_sched_pkg;

    localparam int SEND_LOG_DEF = 2;
    localparam int RECV_LOG_DEF = 2;

    // Payload widths: (2**log - 1) bytes, expressed in bits.
    function automatic int bits_send_max(input int log_b);
        return ((1 << log_b) - 1) << 3;
    endfunction

    function automatic int bits_recv_max(input int log_b);
        return ((1 << log_b) - 1) << 3;
    endfunction

    localparam int BITS_SEND_DEF = bits_send_max(SEND_LOG_DEF);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        RESP,
        GAP
    } state_t;

    // Transaction fields held stable on the controller inputs from LATCH
    // until the FSM returns to IDLE. Sized by the package default widths.
    typedef struct packed {
        logic [7:0]               addr;
        logic [BITS_SEND_DEF-1:0] data;
        logic [SEND_LOG_DEF-1:0]  nsend;
        logic [RECV_LOG_DEF-1:0]  nrecv;
    } txn_t;

endpackage

// File: rtl/i2c_txn_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational N-way round-robin picker. Returns the first asserted request
// at or after i_ptr, wrapping past N-1 back to 0.
//   i_req   : request vector
//   i_ptr   : search start index (0..N-1)
//   o_valid : any request asserted
//   o_idx   : winning index (0 when o_valid is low)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N     = 3,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] ptr,
                                                  input int off);
        int s;
        s = int'(ptr) + off;
        if (s >= N) s = s - N;
        return IDX_W'(s);
    endfunction

    // Scan from the farthest offset down to 0 so the nearest hit overwrites.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[wrap_idx(i_ptr, i)]) begin
                o_valid = 1'b1;
                o_idx   = wrap_idx(i_ptr, i);
            end
        end
    end

endmodule

// File: rtl/i2c_txn_scheduler.sv
// -----------------------------------------------------------------------------
// i2c_txn_scheduler
// Shares one I2C controller between N_REQ requesters. Round-robin grant,
// latches the winner's transaction onto the controller, pulses ctl_start,
// follows ctl_busy to completion and returns done/err plus received data.
//
// Ports
//   i_clk, i_rst_n             clock, async active-low reset
//   i_req                      level requests, held until done
//   i_req_addr/data/nsend/nrecv  packed per-requester transaction fields
//   o_done, o_err              one-cycle pulses to the granted requester
//   o_rx_data                  received data, updated on completion
//   o_active                   high from grant through the post-busy gap
//   o_grant_idx                current / last granted requester
//   o_ctl_*                    controller start/addr/data/counts
//   i_ctl_busy/nack/rx_data    controller status
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a request while the bus is idle
// LATCH     | copy winner's fields to ctl_*, clear flags and counters
// START     | ctl_start held high for START_CYCLES
// WAIT_BUSY | waiting for ctl_busy to rise, bounded by the timeout
// WAIT_DONE | controller busy; collect NACK, capture rx data on busy fall
// RESP      | done/err pulse to the granted requester, advance pointer
// GAP       | enforced idle time before the next grant
// -----------------------------------------------------------------------------
module i2c_txn_scheduler
    import i2c_sched_pkg::*;
#(
    parameter  int N_REQ             = 3,
    parameter  int BYTES_SEND_LOG    = SEND_LOG_DEF,
    parameter  int BYTES_RECEIVE_LOG = RECV_LOG_DEF,
    parameter  int BITS_SEND_MAX     = bits_send_max(BYTES_SEND_LOG),
    parameter  int BITS_RECV_MAX     = bits_recv_max(BYTES_RECEIVE_LOG),
    parameter  int START_CYCLES      = 13,
    parameter  int GAP_CYCLES        = 25,
    parameter  int TIMEOUT_CYCLES    = 1024,
    localparam int IDX_W             = $clog2(N_REQ)
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic [N_REQ-1:0]                    i_req,
    input  logic [N_REQ*8-1:0]                  i_req_addr,
    input  logic [N_REQ*BITS_SEND_MAX-1:0]      i_req_data,
    input  logic [N_REQ*BYTES_SEND_LOG-1:0]     i_req_nsend,
    input  logic [N_REQ*BYTES_RECEIVE_LOG-1:0]  i_req_nrecv,
    output logic [N_REQ-1:0]                    o_done,
    output logic [N_REQ-1:0]                    o_err,
    output logic [BITS_RECV_MAX-1:0]            o_rx_data,
    output logic                                o_active,
    output logic [IDX_W-1:0]                    o_grant_idx,
    output logic                                o_ctl_start,
    output logic [7:0]                          o_ctl_addr,
    output logic [BITS_SEND_MAX-1:0]            o_ctl_data,
    output logic [BYTES_SEND_LOG-1:0]           o_ctl_nsend,
    output logic [BYTES_RECEIVE_LOG-1:0]        o_ctl_nrecv,
    input  logic                                i_ctl_busy,
    input  logic                                i_ctl_nack,
    input  logic [BITS_RECV_MAX-1:0]            i_ctl_rx_data
);

    localparam int PH_MAX = (START_CYCLES > GAP_CYCLES) ? START_CYCLES : GAP_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    state_t                   r_state;
    state_t                   w_next;
    logic [IDX_W-1:0]         r_ptr;
    logic [IDX_W-1:0]         r_grant;
    logic                     w_arb_valid;
    logic [IDX_W-1:0]         w_arb_idx;
    txn_t                     r_txn;
    logic [PH_W-1:0]          r_ph_cnt;
    logic [TO_W-1:0]          r_to_cnt;
    logic                     r_busy_seen;
    logic                     r_nack;
    logic                     r_timeout;
    logic [BITS_RECV_MAX-1:0] r_rx;
    logic [N_REQ-1:0]         w_onehot;

    logic [7:0]                   w_addr_arr  [N_REQ];
    logic [BITS_SEND_MAX-1:0]     w_data_arr  [N_REQ];
    logic [BYTES_SEND_LOG-1:0]    w_nsend_arr [N_REQ];
    logic [BYTES_RECEIVE_LOG-1:0] w_nrecv_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_addr_arr[g]  = i_req_addr[g*8 +: 8];
        assign w_data_arr[g]  = i_req_data[g*BITS_SEND_MAX +: BITS_SEND_MAX];
        assign w_nsend_arr[g] = i_req_nsend[g*BYTES_SEND_LOG +: BYTES_SEND_LOG];
        assign w_nrecv_arr[g] = i_req_nrecv[g*BYTES_RECEIVE_LOG +: BYTES_RECEIVE_LOG];
    end

    rr_arbiter #(.N(N_REQ)) u_arb (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_valid (w_arb_valid),
        .o_idx   (w_arb_idx)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:      if (w_arb_valid && !i_ctl_busy) w_next = LATCH;
            LATCH:     w_next = START;
            // Busy may already have risen while start was still asserted.
            START:     if (r_ph_cnt == '0)
                           w_next = (r_busy_seen || i_ctl_busy) ? WAIT_DONE : WAIT_BUSY;
            WAIT_BUSY: if (i_ctl_busy)           w_next = WAIT_DONE;
                       else if (r_to_cnt == '0)  w_next = RESP;
            WAIT_DONE: if (!i_ctl_busy)          w_next = RESP;
            RESP:      w_next = GAP;
            GAP:       if (r_ph_cnt == '0)       w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr       <= '0;
            r_grant     <= '0;
            r_txn       <= '0;
            r_ph_cnt    <= '0;
            r_to_cnt    <= '0;
            r_busy_seen <= 1'b0;
            r_nack      <= 1'b0;
            r_timeout   <= 1'b0;
            r_rx        <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_arb_valid && !i_ctl_busy) r_grant <= w_arb_idx;
                end
                LATCH: begin
                    r_txn.addr  <= w_addr_arr[r_grant];
                    r_txn.data  <= w_data_arr[r_grant];
                    r_txn.nsend <= w_nsend_arr[r_grant];
                    r_txn.nrecv <= w_nrecv_arr[r_grant];
                    r_busy_seen <= 1'b0;
                    r_nack      <= 1'b0;
                    r_timeout   <= 1'b0;
                    r_ph_cnt    <= PH_W'(START_CYCLES - 1);
                    // Timeout window opens on the first START cycle.
                    r_to_cnt    <= TO_W'(TIMEOUT_CYCLES - 1);
                end
                START: begin
                    if (r_ph_cnt != '0) r_ph_cnt <= r_ph_cnt - 1'b1;
                    if (r_to_cnt != '0) r_to_cnt <= r_to_cnt - 1'b1;
                    if (i_ctl_busy)     r_busy_seen <= 1'b1;
                end
                WAIT_BUSY: begin
                    if (r_to_cnt != '0) r_to_cnt <= r_to_cnt - 1'b1;
                    if (!i_ctl_busy && r_to_cnt == '0) r_timeout <= 1'b1;
                end
                WAIT_DONE: begin
                    if (i_ctl_busy && i_ctl_nack) r_nack <= 1'b1;
                    if (!i_ctl_busy)              r_rx   <= i_ctl_rx_data;
                end
                RESP: begin
                    r_ptr    <= (r_grant == IDX_W'(N_REQ - 1)) ? '0 : r_grant + 1'b1;
                    r_ph_cnt <= PH_W'(GAP_CYCLES - 1);
                end
                GAP: begin
                    if (r_ph_cnt != '0) r_ph_cnt <= r_ph_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_onehot          = '0;
        w_onehot[r_grant] = 1'b1;
    end

    assign o_done      = (r_state == RESP) ? w_onehot : '0;
    assign o_err       = (r_state == RESP && (r_nack || r_timeout)) ? w_onehot : '0;
    assign o_rx_data   = r_rx;
    assign o_active    = (r_state != IDLE);
    assign o_grant_idx = r_grant;
    assign o_ctl_start = (r_state == START);
    assign o_ctl_addr  = r_txn.addr;
    assign o_ctl_data  = r_txn.data;
    assign o_ctl_nsend = r_txn.nsend;
    assign o_ctl_nrecv = r_txn.nrecv;

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// -----------------------------------------------------------------------------
// tb_i2c_txn_scheduler
// Directed bench: a table of single-requester transactions plus hand-written
// sequences for round-robin ordering, gap spacing and reset mid-transaction.
// A small behavioural controller model drives busy/nack/rx_data.
// -----------------------------------------------------------------------------
module tb_i2c_txn_scheduler;

    localparam int START_C = 13;
    localparam int GAP_C   = 25;
    localparam int TO_C    = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [23:0] req_addr;
    logic [71:0] req_data;
    logic [5:0]  req_nsend;
    logic [5:0]  req_nrecv;
    logic [2:0]  o_done, o_err;
    logic [23:0] o_rx_data;
    logic        o_active;
    logic [1:0]  o_grant_idx;
    logic        o_ctl_start;
    logic [7:0]  o_ctl_addr;
    logic [23:0] o_ctl_data;
    logic [1:0]  o_ctl_nsend, o_ctl_nrecv;
    logic        ctl_busy, ctl_nack;
    logic [23:0] ctl_rx_data;

    always #10 clk = ~clk;

    i2c_txn_scheduler dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req),
        .i_req_addr(req_addr), .i_req_data(req_data),
        .i_req_nsend(req_nsend), .i_req_nrecv(req_nrecv),
        .o_done(o_done), .o_err(o_err), .o_rx_data(o_rx_data),
        .o_active(o_active), .o_grant_idx(o_grant_idx),
        .o_ctl_start(o_ctl_start), .o_ctl_addr(o_ctl_addr),
        .o_ctl_data(o_ctl_data), .o_ctl_nsend(o_ctl_nsend),
        .o_ctl_nrecv(o_ctl_nrecv), .i_ctl_busy(ctl_busy),
        .i_ctl_nack(ctl_nack), .i_ctl_rx_data(ctl_rx_data)
    );

    int n_total = 0;
    int n_bad   = 0;

    // controller model settings
    int          m_delay, m_len;
    bit          m_never, m_nack;
    logic [23:0] m_rx;

    // monitor records (updated on negedge)
    int          cyc = 0;
    int          start_cyc, start_run, start_len;
    int          done_cnt = 0, done_cyc, fall_cyc, act_fall = 0;
    logic [2:0]  done_vec, err_vec;
    logic [23:0] rx_done;
    logic [7:0]  snap_addr;
    logic [23:0] snap_data;
    logic [1:0]  snap_nsend, snap_nrecv;
    int          grant_a [64];
    int          gidx_a  [64];
    int          fall_a  [64];
    int          grant_n = 0, fall_n = 0;

    initial begin : monitor_and_model
        logic p_start, p_active, rise;
        int   m_phase, m_cnt;
        p_start = 0; p_active = 0; m_phase = 0; m_cnt = 0;
        ctl_busy = 0; ctl_nack = 0; ctl_rx_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            rise = o_ctl_start && !p_start;
            if (rise) begin
                start_cyc = cyc; start_run = 0;
                snap_addr = o_ctl_addr; snap_data = o_ctl_data;
                snap_nsend = o_ctl_nsend; snap_nrecv = o_ctl_nrecv;
            end
            if (o_ctl_start) start_run++;
            if (!o_ctl_start && p_start) start_len = start_run;
            if (o_done != 3'b000) begin
                done_cnt++; done_cyc = cyc;
                done_vec = o_done; err_vec = o_err; rx_done = o_rx_data;
            end
            if (o_active && !p_active && grant_n < 64) begin
                grant_a[grant_n] = cyc; gidx_a[grant_n] = int'(o_grant_idx); grant_n++;
            end
            if (!o_active && p_active) act_fall = cyc;
            p_start = o_ctl_start; p_active = o_active;

            if (!rst_n) begin
                m_phase = 0; ctl_busy = 0; ctl_nack = 0;
            end else begin
                case (m_phase)
                    0: if (rise && !m_never) begin m_phase = 1; m_cnt = m_delay; end
                    1: begin
                        m_cnt--;
                        if (m_cnt == 0) begin
                            ctl_busy = 1; ctl_rx_data = m_rx; m_phase = 2; m_cnt = m_len;
                        end
                    end
                    default: begin
                        m_cnt--;
                        ctl_nack = m_nack && (m_cnt == m_len / 2);
                        if (m_cnt == 0) begin
                            ctl_busy = 0; ctl_nack = 0; m_phase = 0;
                            fall_cyc = cyc;
                            if (fall_n < 64) begin fall_a[fall_n] = cyc; fall_n++; end
                        end
                    end
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_done(input int d0, input string nm);
        int t = 0;
        while (done_cnt == d0 && t < 3000) begin tick(); t++; end
        if (done_cnt == d0) begin
            n_total++; n_bad++;
            $display("FAIL %s: got no done expected a done pulse", nm);
        end
    endtask

    task automatic wait_idle(input int after, input string nm);
        int t = 0;
        while (act_fall <= after && t < 200) begin tick(); t++; end
        if (act_fall <= after) begin
            n_total++; n_bad++;
            $display("FAIL %s: got active stuck high expected fall", nm);
        end
    endtask

    function automatic logic [2:0] onehot(input int i);
        logic [2:0] v;
        v = '0; v[i] = 1'b1;
        return v;
    endfunction

    typedef struct {
        int          idx;
        logic [7:0]  addr;
        logic [23:0] data;
        logic [1:0]  nsend, nrecv;
        int          delay, len;
        bit          never, nack;
        logic [23:0] rx;
        bit          err;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int d0, dc, g0, f0, t;

        vecs[0] = '{0, 8'h8E, 24'hCAF1AF, 2'd3, 2'd0, 5, 300, 1'b0, 1'b0, 24'h000000, 1'b0};
        vecs[1] = '{0, 8'h9F, 24'h000000, 2'd0, 2'd2, 5, 30,  1'b0, 1'b0, 24'h00A55A, 1'b0};
        vecs[2] = '{2, 8'hFD, 24'h000011, 2'd1, 2'd0, 4, 40,  1'b0, 1'b1, 24'h00BEEF, 1'b1};
        vecs[3] = '{1, 8'h52, 24'h000000, 2'd0, 2'd0, 20, 10, 1'b0, 1'b0, 24'h123456, 1'b0};
        vecs[4] = '{0, 8'h9E, 24'h0000AB, 2'd1, 2'd1, 5, 10,  1'b1, 1'b0, 24'h123456, 1'b1};

        rst_n = 0; req = '0; req_addr = '0; req_data = '0; req_nsend = '0; req_nrecv = '0;
        m_delay = 5; m_len = 40; m_never = 0; m_nack = 0; m_rx = '0;

        // reset state
        #35;
        chk("rst_done", o_done, 3'b000);
        chk("rst_err", o_err, 3'b000);
        chk("rst_active", o_active, 1'b0);
        chk("rst_start", o_ctl_start, 1'b0);
        chk("rst_grant", o_grant_idx, 2'd0);
        chk("rst_rx", o_rx_data, 24'h0);
        chk("rst_addr", o_ctl_addr, 8'h0);
        tick(); rst_n = 1; tick();

        // three simultaneous requests from pointer 0
        req_addr = {8'hA2, 8'hA1, 8'hA0};
        m_delay = 5; m_len = 40; m_rx = 24'h000111;
        g0 = grant_n; f0 = fall_n;
        req = 3'b111;
        for (int j = 0; j < 3; j++) begin
            d0 = done_cnt;
            wait_done(d0, "rr_done");
            chk("rr_order", done_vec, onehot(j));
            chk("rr_err", err_vec, 3'b000);
            req[j] = 1'b0;
        end
        for (int j = 0; j < 3; j++) chk("rr_grant_idx", gidx_a[g0+j], j);
        for (int j = 0; j < 2; j++)
            chk("rr_gap", (grant_a[g0+j+1] - fall_a[f0+j]) >= GAP_C, 1'b1);
        wait_idle(done_cyc, "rr_idle");

        // table of single transactions
        for (int v = 0; v < 5; v++) begin
            req_addr[vecs[v].idx*8 +: 8]   = vecs[v].addr;
            req_data[vecs[v].idx*24 +: 24] = vecs[v].data;
            req_nsend[vecs[v].idx*2 +: 2]  = vecs[v].nsend;
            req_nrecv[vecs[v].idx*2 +: 2]  = vecs[v].nrecv;
            m_delay = vecs[v].delay; m_len = vecs[v].len;
            m_never = vecs[v].never; m_nack = vecs[v].nack; m_rx = vecs[v].rx;
            d0 = done_cnt; g0 = grant_n;
            req = onehot(vecs[v].idx);
            wait_done(d0, "vec_done");
            dc = done_cyc;
            req = '0;
            chk("vec_grant", gidx_a[g0], vecs[v].idx);
            chk("vec_ctl_addr", snap_addr, vecs[v].addr);
            chk("vec_ctl_data", snap_data, vecs[v].data);
            chk("vec_ctl_nsend", snap_nsend, vecs[v].nsend);
            chk("vec_ctl_nrecv", snap_nrecv, vecs[v].nrecv);
            chk("vec_start_len", start_len, START_C);
            chk("vec_done", done_vec, onehot(vecs[v].idx));
            chk("vec_err", err_vec, vecs[v].err ? onehot(vecs[v].idx) : 3'b000);
            chk("vec_rx", rx_done, vecs[v].rx);
            if (vecs[v].never) chk("vec_timeout_lat", done_cyc - start_cyc, TO_C);
            else               chk("vec_done_lat", done_cyc - fall_cyc, 1);
            wait_idle(dc, "vec_idle");
            chk("vec_gap_len", act_fall - dc, GAP_C + 1);
            chk("vec_done_once", done_cnt - d0, 1);
            chk("vec_rx_held", o_rx_data, vecs[v].rx);
        end

        // reset while in WAIT_DONE; pointer is 1 here so requester 1 wins first
        req_addr = {8'hA2, 8'h31, 8'h30};
        m_delay = 5; m_len = 200; m_never = 0; m_nack = 0; m_rx = 24'h000777;
        req = 3'b011;
        t = 0;
        while (!(ctl_busy && !o_ctl_start && o_active) && t < 100) begin tick(); t++; end
        chk("rst_pre_grant", o_grant_idx, 2'd1);
        d0 = done_cnt;
        rst_n = 0; #1;
        chk("rst_mid_start", o_ctl_start, 1'b0);
        chk("rst_mid_done", o_done, 3'b000);
        chk("rst_mid_active", o_active, 1'b0);
        chk("rst_mid_grant", o_grant_idx, 2'd0);
        tick(); tick(); tick();
        rst_n = 1;
        g0 = grant_n; t = 0;
        while (grant_n == g0 && t < 50) begin tick(); t++; end
        chk("rst_regrant_idx", gidx_a[g0], 0);
        chk("rst_no_done", done_cnt - d0, 0);
        wait_done(d0, "rst_done0");
        chk("rst_done0_vec", done_vec, 3'b001);
        chk("rst_done0_addr", snap_addr, 8'h30);
        req[0] = 1'b0;
        d0 = done_cnt;
        wait_done(d0, "rst_done1");
        chk("rst_done1_vec", done_vec, 3'b010);
        req = '0;
        wait_idle(done_cyc, "rst_idle");

        // reset while ctl_start is high
        req = 3'b100;
        t = 0;
        while (!o_ctl_start && t < 100) begin tick(); t++; end
        tick(); tick();
        chk("start_pre", o_ctl_start, 1'b1);
        rst_n = 0; #1;
        chk("start_drop", o_ctl_start, 1'b0);
        req = '0;
        tick(); rst_n = 1; tick(); tick();
        chk("start_post_idle", o_active, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
